// File: rtl/avalon_ram_pkg.sv
// rtl/avalon_ram_pkg.sv - shared types and constants for the Avalon RAM responder
package avalon_ram_pkg;

  // Bytes per memory word; word index = byte offset >> log2(WORD_BYTES)
  localparam int WORD_BYTES = 4;

  // Wait-state counter width (WAIT_CYCLES range 0..15)
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } ram_state_t;

endpackage

// File: rtl/ram_waitstate_ctrl.sv
// rtl/ram_waitstate_ctrl.sv - wait-state FSM and counter for the Avalon RAM responder
module ram_waitstate_ctrl
  import avalon_ram_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic waitrequest,
  output logic commit
);

  // The IDLE cycle that sees the request is the first stall cycle, so the
  // counter holds the number of stall cycles still to come after it.
  localparam logic [WAIT_CNT_W-1:0] LOAD_VAL =
    WAIT_CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  ram_state_t             state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state, counter and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    waitrequest = 1'b0;
    commit      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
          end else begin
            waitrequest = 1'b1;
            cnt_d       = LOAD_VAL;
            state_d     = (LOAD_VAL == '0) ? ACK : WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          // master abandoned the transfer: nothing commits
          state_d = IDLE;
        end else begin
          waitrequest = 1'b1;
          cnt_d       = cnt_q - WAIT_CNT_W'(1);
          if (cnt_q <= WAIT_CNT_W'(1)) state_d = ACK;
        end
      end
      ACK: begin
        commit  = req;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      waitrequest = 1'b1;
      commit      = 1'b0;
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/avalon_ram_slave.sv
// rtl/avalon_ram_slave.sv - Avalon-MM RAM responder with byte lanes and preload; AVALON_RAM_WAITSTATE_EN enables wait states
module avalon_ram_slave
  import avalon_ram_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter int          LOAD_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            address,
  input  logic                   write,
  input  logic                   read,
  output logic                   waitrequest,
  input  logic [31:0]            writedata,
  input  logic [3:0]             byteenable,
  output logic [31:0]            readdata,
  input  logic                   inst_input,
  input  logic [LOAD_ADDR_W-1:0] inst_addr,
  input  logic [31:0]            instruction
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int LANE_SH = $clog2(WORD_BYTES);

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [31:0]      mem_d [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             in_range;
  logic [31:0]      pre_off;
  logic [IDX_W-1:0] pre_idx;
  logic             pre_in_range;
  logic             commit;

  // Bus and preload address decode; addresses below BASE_ADDR wrap high and fall out of range
  assign offset       = address - BASE_ADDR;
  assign word_idx     = offset[IDX_W+1:2];
  assign in_range     = (offset >> LANE_SH) < 32'(DEPTH_WORDS);
  assign pre_off      = 32'(inst_addr);
  assign pre_idx      = pre_off[IDX_W+1:2];
  assign pre_in_range = (pre_off >> LANE_SH) < 32'(DEPTH_WORDS);

`ifdef AVALON_RAM_WAITSTATE_EN
  ram_waitstate_ctrl #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_waitstate (
    .clk         (clk),
    .reset       (reset),
    .req         (read | write),
    .waitrequest (waitrequest),
    .commit      (commit)
  );
`else
  localparam int unused_wait_cycles = WAIT_CYCLES;
  // Every transfer completes in the cycle it is presented
  assign waitrequest = reset;
  assign commit      = (read | write) & ~reset;
`endif

  // Read data only while a pure read is completing; simultaneous read+write counts as a write
  assign readdata = (read && !write && !waitrequest && in_range) ? mem_q[word_idx] : '0;

  // Next memory image: lane-merged bus write, then preload on top so it wins a same-word collision
  always_comb begin
    mem_d = mem_q;
    if (commit && write && in_range) begin
      for (int l = 0; l < WORD_BYTES; l++) begin
        if (byteenable[l]) mem_d[word_idx][8*l +: 8] = writedata[8*l +: 8];
      end
    end
    if (inst_input && pre_in_range) mem_d[pre_idx] = instruction;
  end

  // Memory array; reset clears every word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_avalon_ram_slave.sv
// tb/tb_avalon_ram_slave.sv - directed self-checking bench for avalon_ram_slave
module tb_avalon_ram_slave;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef AVALON_RAM_WAITSTATE_EN
  localparam int NW = 3;
`else
  localparam int NW = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        inst_input;
  logic [7:0]  inst_addr;
  logic [31:0] instruction;

  int checks = 0;
  int errors = 0;

  avalon_ram_slave #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (3),
    .LOAD_ADDR_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .write       (write),
    .read        (read),
    .waitrequest (waitrequest),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .readdata    (readdata),
    .inst_input  (inst_input),
    .inst_addr   (inst_addr),
    .instruction (instruction)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output int waits);
    bit done = 0;
    address = addr; writedata = wdata; byteenable = be; read = rd; write = wr;
    waits = 0; rdata = 'x;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!waitrequest) begin
        rdata = readdata;
        done  = 1;
        break;
      end
      waits++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h: waitrequest stuck high, required low within 40 cycles", addr);
    end
    step();
    read = 0; write = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    inst_input = 1; inst_addr = a; instruction = d;
    step();
    inst_input = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r; int w;
    reset = 1; step(); step();
    reset = 0;
    preload(8'h10, 32'hCAFE_F00D);
    reset = 1; read = 1; address = 32'h10;
    @(negedge clk);
    checks++;
    if (waitrequest !== 1'b1) begin errors++; $display("FAIL reset_waitreq got %b want 1", waitrequest); end
    checks++;
    if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata got %h want 0", readdata); end
    step();
    reset = 0; read = 0;
    @(negedge clk);
    checks++;
    if (waitrequest !== 1'b0 || readdata !== 32'h0) begin
      errors++; $display("FAIL idle_outputs got wr=%b rd=%h want wr=0 rd=0", waitrequest, readdata);
    end
    step();
    bus_xfer(1, 0, BASE + 32'h10, 0, 0, r, w);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_clears got %h want 0", r); end
    checks++;
    if (w !== NW) begin errors++; $display("FAIL read_waits got %0d want %0d", w, NW); end
  endtask

  task automatic test_preload();
    logic [31:0] r; int w;
    preload(8'h04, 32'h2402_0010);
    bus_xfer(1, 0, BASE + 32'h4, 0, 0, r, w);
    checks++;
    if (r !== 32'h2402_0010) begin errors++; $display("FAIL preload_read got %h want 24020010", r); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r; int w;
    preload(8'h08, 32'h1122_3344);
    bus_xfer(0, 1, BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, r, w);
    checks++;
    if (w !== NW) begin errors++; $display("FAIL write_waits got %0d want %0d", w, NW); end
    bus_xfer(1, 0, BASE + 32'h8, 0, 0, r, w);
    checks++;
    if (r !== 32'h11BB_33DD) begin errors++; $display("FAIL lane_merge got %h want 11bb33dd", r); end
    bus_xfer(0, 1, BASE + 32'h8, 32'hFFFF_FFFF, 4'b0000, r, w);
    bus_xfer(1, 0, BASE + 32'hB, 0, 0, r, w);
    checks++;
    if (r !== 32'h11BB_33DD) begin errors++; $display("FAIL be_zero_noop got %h want 11bb33dd", r); end
  endtask

  task automatic test_wait_pattern();
    logic exp;
    address = BASE + 32'h4; read = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp = ((k % (NW + 1)) != NW);
      checks++;
      if (waitrequest !== exp) begin
        errors++; $display("FAIL wait_pattern cycle %0d got %b want %b", k, waitrequest, exp);
      end
      if (!exp) begin
        checks++;
        if (readdata !== 32'h2402_0010) begin
          errors++; $display("FAIL held_read cycle %0d got %h want 24020010", k, readdata);
        end
      end
    end
    step();
    read = 0;
    step();
  endtask

  task automatic test_drop();
    logic [31:0] r, exp; int w;
    preload(8'h0C, 32'h0000_5555);
    address = BASE + 32'hC; writedata = 32'hDEAD_BEEF; byteenable = 4'hF; write = 1;
    step();
    write = 0;
    step();
`ifdef AVALON_RAM_WAITSTATE_EN
    exp = 32'h0000_5555;
`else
    exp = 32'hDEAD_BEEF;
`endif
    bus_xfer(1, 0, BASE + 32'hC, 0, 0, r, w);
    checks++;
    if (r !== exp) begin errors++; $display("FAIL dropped_write got %h want %h", r, exp); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int w;
    bus_xfer(0, 1, BASE + 32'h20, 32'h1234_5678, 4'hF, r, w);
    bus_xfer(1, 0, BASE + 32'h20, 0, 0, r, w);
    checks++;
    if (r !== 32'h1234_5678) begin errors++; $display("FAIL read_after_write got %h want 12345678", r); end
    bus_xfer(1, 1, BASE + 32'h30, 32'h0BAD_CAFE, 4'hF, r, w);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rw_both_readdata got %h want 0", r); end
    bus_xfer(1, 0, BASE + 32'h30, 0, 0, r, w);
    checks++;
    if (r !== 32'h0BAD_CAFE) begin errors++; $display("FAIL rw_both_write got %h want 0badcafe", r); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] r; int w;
    preload(8'h00, 32'hA5A5_A5A5);
    bus_xfer(0, 1, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'hF, r, w);
    checks++;
    if (w !== NW) begin errors++; $display("FAIL oor_write_waits got %0d want %0d", w, NW); end
    bus_xfer(1, 0, BASE + 32'(4 * DEPTH), 0, 0, r, w);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL oor_read got %h want 0", r); end
    bus_xfer(1, 0, BASE, 0, 0, r, w);
    checks++;
    if (r !== 32'hA5A5_A5A5) begin errors++; $display("FAIL oor_word0 got %h want a5a5a5a5", r); end
  endtask

  task automatic test_collision();
    logic [31:0] r; int w;
    inst_input = 1; inst_addr = 8'h40; instruction = 32'h0102_0304;
    bus_xfer(0, 1, BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, r, w);
    inst_input = 0;
    bus_xfer(1, 0, BASE + 32'h40, 0, 0, r, w);
    checks++;
    if (r !== 32'h0102_0304) begin errors++; $display("FAIL preload_wins got %h want 01020304", r); end
    inst_input = 1; inst_addr = 8'h44; instruction = 32'h5566_7788;
    bus_xfer(0, 1, BASE + 32'h48, 32'h99AA_BBCC, 4'hF, r, w);
    inst_input = 0;
    bus_xfer(1, 0, BASE + 32'h44, 0, 0, r, w);
    checks++;
    if (r !== 32'h5566_7788) begin errors++; $display("FAIL split_preload got %h want 55667788", r); end
    bus_xfer(1, 0, BASE + 32'h48, 0, 0, r, w);
    checks++;
    if (r !== 32'h99AA_BBCC) begin errors++; $display("FAIL split_write got %h want 99aabbcc", r); end
  endtask

  initial begin
    reset = 1; address = 0; write = 0; read = 0; writedata = 0; byteenable = 0;
    inst_input = 0; inst_addr = 0; instruction = 0;
    #1;
    test_reset();
    test_preload();
    test_byte_lanes();
    test_wait_pattern();
    test_drop();
    test_back_to_back();
    test_out_of_range();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
